// File: rtl/load_size_unit_pkg.sv
// Shared load/store size definitions: size codes and the load FSM state encoding.
package load_size_unit_pkg;

    // Size select codes, common to the load and store paths.
    localparam logic [1:0] LS_NONE = 2'b00;
    localparam logic [1:0] LS_WORD = 2'b01;
    localparam logic [1:0] LS_HALF = 2'b10;
    localparam logic [1:0] LS_BYTE = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StWait = 2'b10,
        StDone = 2'b11
    } ls_state_e;

endpackage

// File: rtl/load_size_unit_extract.sv
// Extracts word/half/byte from the low lanes of a memory word and zero/sign-extends it.
module ls_extract
    import load_size_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] value
);

    // Half and byte live in bits 15:0 / 7:0, matching the store-side lanes.
    always_comb begin
        value = 32'h0;
        unique case (size)
            LS_WORD: value = word;
            LS_HALF: value = {{16{sign_ext & word[15]}}, word[15:0]};
            LS_BYTE: value = {{24{sign_ext & word[7]}}, word[7:0]};
            LS_NONE: value = 32'h0;
            default: value = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_size_unit.sv
// Load path: issues one memory read, waits MEM_LATENCY cycles, extracts and extends the result.
module load_size_unit
    import load_size_unit_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2  // 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  ls_control,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data
);

    localparam logic [3:0] CntLoad = 4'(MEM_LATENCY - 1);

    ls_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_q, mem_rd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] ext_value;

    ls_extract u_extract (
        .word     (mem_data_in),
        .size     (size_q),
        .sign_ext (sext_q),
        .value    (ext_value)
    );

    // Next-state logic; outputs are computed one cycle ahead so they come straight off flops.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        sext_d      = sext_q;
        mem_addr_d  = mem_addr_q;
        load_data_d = load_data_q;
        mem_rd_d    = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && (ls_control != LS_NONE)) begin
                    state_d    = StReq;
                    mem_addr_d = addr;
                    size_d     = ls_control;
                    sext_d     = sign_ext;
                    mem_rd_d   = 1'b1;  // high during the REQ cycle
                end
            end
            StReq: begin
                cnt_d   = CntLoad;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    load_data_d = ext_value;
                    done_d      = 1'b1;  // high during the DONE cycle
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            size_q      <= LS_NONE;
            sext_q      <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            load_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            load_data_q <= load_data_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_load_size_unit.sv
// Directed bench for load_size_unit (MEM_LATENCY = 2 and MEM_LATENCY = 1 instances).
module tb_load_size_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  ls_control;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        busy;
    logic        done;
    logic [31:0] load_data;

    logic        start2;
    logic [1:0]  ls_control2;
    logic        sign_ext2;
    logic [31:0] addr2;
    logic [31:0] mem_data_in2;
    logic [31:0] mem_addr2;
    logic        mem_rd2;
    logic        busy2;
    logic        done2;
    logic [31:0] load_data2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_size_unit #(.MEM_LATENCY(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ls_control  (ls_control),
        .sign_ext    (sign_ext),
        .addr        (addr),
        .mem_data_in (mem_data_in),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .busy        (busy),
        .done        (done),
        .load_data   (load_data)
    );

    load_size_unit #(.MEM_LATENCY(1)) dut_l1 (
        .clk         (clk),
        .reset       (reset),
        .start       (start2),
        .ls_control  (ls_control2),
        .sign_ext    (sign_ext2),
        .addr        (addr2),
        .mem_data_in (mem_data_in2),
        .mem_addr    (mem_addr2),
        .mem_rd      (mem_rd2),
        .busy        (busy2),
        .done        (done2),
        .load_data   (load_data2)
    );

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full request: start at cycle 0, data valid only at cycle 3, done expected at cycle 4.
    task automatic do_load(input string tag, input logic [1:0] sz, input logic se,
                           input logic [31:0] a, input logic [31:0] w, input logic [31:0] exp);
        ls_control  = sz;
        sign_ext    = se;
        addr        = a;
        start       = 1'b1;
        mem_data_in = ~w;
        step();  // cycle 1
        start      = 1'b0;
        ls_control = 2'b01;
        sign_ext   = ~se;
        addr       = ~a;
        check({tag, " c1 mem_rd"}, 32'(mem_rd), 32'd1);
        check({tag, " c1 mem_addr"}, mem_addr, a);
        check({tag, " c1 busy"}, 32'(busy), 32'd1);
        step();  // cycle 2
        check({tag, " c2 mem_rd"}, 32'(mem_rd), 32'd0);
        check({tag, " c2 done"}, 32'(done), 32'd0);
        step();  // cycle 3
        mem_data_in = w;
        check({tag, " c3 done"}, 32'(done), 32'd0);
        check({tag, " c3 mem_addr"}, mem_addr, a);
        step();  // cycle 4
        mem_data_in = ~w;
        check({tag, " c4 done"}, 32'(done), 32'd1);
        check({tag, " c4 load_data"}, load_data, exp);
        step();  // cycle 5
        check({tag, " c5 done"}, 32'(done), 32'd0);
        check({tag, " c5 busy"}, 32'(busy), 32'd0);
        check({tag, " c5 load_data held"}, load_data, exp);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        ls_control   = 2'b00;
        sign_ext     = 1'b0;
        addr         = 32'h0;
        mem_data_in  = 32'h0;
        start2       = 1'b0;
        ls_control2  = 2'b00;
        sign_ext2    = 1'b0;
        addr2        = 32'h0;
        mem_data_in2 = 32'h0;
        step();
        step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset mem_rd", 32'(mem_rd), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset load_data", load_data, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        reset = 1'b0;

        do_load("word", 2'b01, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("half z", 2'b10, 1'b0, 32'h0000_2000, 32'h1234_BEEF, 32'h0000_BEEF);
        do_load("half s", 2'b10, 1'b1, 32'h0000_2004, 32'h1234_BEEF, 32'hFFFF_BEEF);
        do_load("half s pos", 2'b10, 1'b1, 32'h0000_2008, 32'h1234_7EEF, 32'h0000_7EEF);
        do_load("byte s", 2'b11, 1'b1, 32'h0000_3000, 32'hCAFE_80EF, 32'hFFFF_FFEF);
        do_load("byte z", 2'b11, 1'b0, 32'h0000_3004, 32'hCAFE_80EF, 32'h0000_00EF);
        do_load("byte s pos", 2'b11, 1'b1, 32'h0000_3008, 32'hCAFE_807F, 32'h0000_007F);

        // start while busy and ls_control flipped during WAIT must not disturb the half request.
        ls_control  = 2'b10;
        sign_ext    = 1'b1;
        addr        = 32'h0000_A000;
        start       = 1'b1;
        mem_data_in = 32'h0;
        step();  // cycle 1
        start = 1'b0;
        step();  // cycle 2
        start      = 1'b1;
        ls_control = 2'b01;
        addr       = 32'h0000_B000;
        step();  // cycle 3
        start       = 1'b0;
        sign_ext    = 1'b0;
        mem_data_in = 32'h1234_BEEF;
        check("restart c3 mem_rd", 32'(mem_rd), 32'd0);
        check("restart c3 mem_addr", mem_addr, 32'h0000_A000);
        step();  // cycle 4
        mem_data_in = 32'h0;
        check("restart c4 done", 32'(done), 32'd1);
        check("restart c4 load_data", load_data, 32'hFFFF_BEEF);
        step();  // cycle 5
        check("restart c5 busy", 32'(busy), 32'd0);
        check("restart c5 mem_rd", 32'(mem_rd), 32'd0);
        step();  // cycle 6
        check("restart c6 done", 32'(done), 32'd0);
        check("restart c6 busy", 32'(busy), 32'd0);

        // start during the DONE cycle is ignored.
        ls_control  = 2'b01;
        sign_ext    = 1'b0;
        addr        = 32'h0000_C000;
        start       = 1'b1;
        mem_data_in = 32'h0000_0055;
        step();
        start = 1'b0;
        step();
        step();
        step();  // DONE cycle
        check("donestart c4 done", 32'(done), 32'd1);
        start      = 1'b1;
        ls_control = 2'b01;
        step();
        start = 1'b0;
        check("donestart c5 busy", 32'(busy), 32'd0);
        check("donestart c5 mem_rd", 32'(mem_rd), 32'd0);
        step();
        check("donestart c6 busy", 32'(busy), 32'd0);

        // Reset during WAIT aborts the request with no done pulse.
        ls_control  = 2'b01;
        addr        = 32'h0000_D000;
        start       = 1'b1;
        mem_data_in = 32'h1111_1111;
        step();  // cycle 1
        start = 1'b0;
        step();  // cycle 2
        reset = 1'b1;
        step();  // cycle 3
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort mem_rd", 32'(mem_rd), 32'd0);
        check("abort load_data", load_data, 32'h0);
        check("abort done", 32'(done), 32'd0);
        check("abort mem_addr", mem_addr, 32'h0);
        step();
        check("abort next done", 32'(done), 32'd0);
        check("abort next busy", 32'(busy), 32'd0);
        do_load("after abort", 2'b11, 1'b1, 32'h0000_E000, 32'h0000_0081, 32'hFFFF_FF81);

        // ls_control = 00 is not a request.
        ls_control = 2'b00;
        addr       = 32'h0000_F000;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("none c%0d mem_rd", i), 32'(mem_rd), 32'd0);
            check($sformatf("none c%0d busy", i), 32'(busy), 32'd0);
            check($sformatf("none c%0d done", i), 32'(done), 32'd0);
            step();
        end

        // MEM_LATENCY = 1: data valid at cycle 2, done at cycle 3.
        ls_control2  = 2'b01;
        addr2        = 32'h0000_0400;
        start2       = 1'b1;
        mem_data_in2 = 32'h0BAD_F00D;
        step();  // cycle 1
        start2 = 1'b0;
        check("l1 c1 mem_rd", 32'(mem_rd2), 32'd1);
        check("l1 c1 mem_addr", mem_addr2, 32'h0000_0400);
        step();  // cycle 2
        mem_data_in2 = 32'hDEAD_BEEF;
        check("l1 c2 mem_rd", 32'(mem_rd2), 32'd0);
        check("l1 c2 done", 32'(done2), 32'd0);
        step();  // cycle 3
        mem_data_in2 = 32'h0BAD_F00D;
        check("l1 c3 done", 32'(done2), 32'd1);
        check("l1 c3 load_data", load_data2, 32'hDEAD_BEEF);
        step();  // cycle 4
        check("l1 c4 done", 32'(done2), 32'd0);
        check("l1 c4 busy", 32'(busy2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
